// File: rtl/energy_coeff_lut_dbuf_pkg.sv
// Shared constants and types for the energy-calibration coefficient LUT.
package energy_cal_pkg;

  // Pipeline depths seen at the block boundary.
  localparam int unsigned LK_LATENCY     = 3;
  localparam int unsigned CPU_RD_LATENCY = 2;

  // cpu_addr field layout: {bank_sel, channel, half}.
  localparam int unsigned ADDR_HALF_BIT  = 0;

  typedef enum logic {
    SWAP_IDLE  = 1'b0,
    SWAP_ARMED = 1'b1
  } swap_state_e;

  // Position of the read bank-select bit for a given channel-index width.
  function automatic int unsigned bank_sel_bit(input int unsigned chan_w);
    return chan_w + 1;
  endfunction

endpackage

// File: rtl/energy_coeff_lut_dbuf_bank.sv
// One coefficient bank: port A is the CPU read/write port (write wins),
// port B is the lookup read port. Both reads are registered.
module energy_coeff_bank #(
  parameter int unsigned AW = 10,
  parameter int unsigned HW = 32
) (
  input  logic            clk,
  input  logic            a_we_lo_i,
  input  logic            a_we_hi_i,
  input  logic [AW-1:0]   a_addr_i,
  input  logic [HW-1:0]   a_wdata_i,
  output logic [2*HW-1:0] a_rdata_o,
  input  logic [AW-1:0]   b_addr_i,
  output logic [2*HW-1:0] b_rdata_o
);

  logic [HW-1:0]   mem_lo [2**AW];
  logic [HW-1:0]   mem_hi [2**AW];
  logic [2*HW-1:0] a_rdata_q;
  logic [2*HW-1:0] b_rdata_q;

  // Per-half writes and registered reads; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (a_we_lo_i) mem_lo[a_addr_i] <= a_wdata_i;
    if (a_we_hi_i) mem_hi[a_addr_i] <= a_wdata_i;
    if (!(a_we_lo_i || a_we_hi_i)) a_rdata_q <= {mem_hi[a_addr_i], mem_lo[a_addr_i]};
    b_rdata_q <= {mem_hi[b_addr_i], mem_lo[b_addr_i]};
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/energy_coeff_lut_dbuf.sv
// Double-buffered per-channel energy-calibration coefficient LUT.
// CPU writes the shadow bank; lookups read the active bank; banks swap on
// the first frame_sync after swap_req.
// Optional build macro COEFF_PARITY_EN adds per-half even parity with
// parity_err / parity_err_cnt outputs.
module energy_coeff_lut_dbuf
  import energy_cal_pkg::*;
#(
  parameter int unsigned CHAN_W  = 10,
  parameter int unsigned COEFF_W = 64,
  parameter int unsigned BUS_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic [CHAN_W+1:0]  cpu_addr,
  input  logic [BUS_W-1:0]   cpu_wdata,
  output logic [BUS_W-1:0]   cpu_rdata,
  output logic               cpu_rvalid,
  input  logic               swap_req,
  input  logic               frame_sync,
  output logic               swap_pending,
  output logic               swap_done,
  output logic               active_bank,
  input  logic               lk_valid,
  input  logic [CHAN_W-1:0]  lk_chan,
  output logic [COEFF_W-1:0] lk_coeff,
  output logic               lk_coeff_valid
`ifdef COEFF_PARITY_EN
  ,
  output logic               parity_err,
  output logic [15:0]        parity_err_cnt
`endif
);

`ifdef COEFF_PARITY_EN
  localparam int unsigned HW = BUS_W + 1;
`else
  localparam int unsigned HW = BUS_W;
`endif
  localparam int unsigned BANK_BIT = bank_sel_bit(CHAN_W);

  // Swap control
  swap_state_e state_q;
  logic        active_bank_q;
  logic        swap_pending_q;
  logic        swap_done_q;

  // CPU side
  logic [CHAN_W-1:0]         cpu_chan;
  logic                      cpu_half;
  logic                      cpu_rd_phys;
  logic [HW-1:0]             cpu_wdata_h;
  logic [1:0]                we_lo;
  logic [1:0]                we_hi;
  logic [2*HW-1:0]           a_rd0, a_rd1;
  logic [CPU_RD_LATENCY-1:0] cpu_rv_q;
  logic                      cpu_rbank_q;
  logic                      cpu_rhalf_q;
  logic [BUS_W-1:0]          cpu_rdata_d, cpu_rdata_q;
  logic [2*HW-1:0]           sel_a;

  // Lookup side
  logic [LK_LATENCY-1:0]     lk_vld_q;
  logic [CHAN_W-1:0]         lk_chan_q;
  logic                      lk_bank1_q;
  logic                      lk_bank2_q;
  logic [2*HW-1:0]           b_rd0, b_rd1;
  logic [2*HW-1:0]           sel_b;
  logic [COEFF_W-1:0]        lk_coeff_d, lk_coeff_q;

  assign cpu_chan    = cpu_addr[CHAN_W:1];
  assign cpu_half    = cpu_addr[ADDR_HALF_BIT];
  assign cpu_rd_phys = cpu_addr[BANK_BIT] ? active_bank_q : ~active_bank_q;

`ifdef COEFF_PARITY_EN
  assign cpu_wdata_h = {^cpu_wdata, cpu_wdata};
`else
  assign cpu_wdata_h = cpu_wdata;
`endif

  // Writes always target the bank that is not active this cycle, so a write
  // on the swap edge lands in the bank that is about to become active.
  assign we_lo[0] = cpu_we & ~cpu_half &  active_bank_q;
  assign we_hi[0] = cpu_we &  cpu_half &  active_bank_q;
  assign we_lo[1] = cpu_we & ~cpu_half & ~active_bank_q;
  assign we_hi[1] = cpu_we &  cpu_half & ~active_bank_q;

  energy_coeff_bank #(.AW(CHAN_W), .HW(HW)) u_bank0 (
    .clk       (clk),
    .a_we_lo_i (we_lo[0]),
    .a_we_hi_i (we_hi[0]),
    .a_addr_i  (cpu_chan),
    .a_wdata_i (cpu_wdata_h),
    .a_rdata_o (a_rd0),
    .b_addr_i  (lk_chan_q),
    .b_rdata_o (b_rd0)
  );

  energy_coeff_bank #(.AW(CHAN_W), .HW(HW)) u_bank1 (
    .clk       (clk),
    .a_we_lo_i (we_lo[1]),
    .a_we_hi_i (we_hi[1]),
    .a_addr_i  (cpu_chan),
    .a_wdata_i (cpu_wdata_h),
    .a_rdata_o (a_rd1),
    .b_addr_i  (lk_chan_q),
    .b_rdata_o (b_rd1)
  );

  // Swap FSM: arm on swap_req, apply on the next frame_sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SWAP_IDLE;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      case (state_q)
        SWAP_IDLE: begin
          if (swap_req) begin
            state_q        <= SWAP_ARMED;
            swap_pending_q <= 1'b1;
          end
        end
        SWAP_ARMED: begin
          if (frame_sync) begin
            state_q        <= SWAP_IDLE;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b1;
            active_bank_q  <= ~active_bank_q;
          end
        end
        default: state_q <= SWAP_IDLE;
      endcase
    end
  end

  // Output-side muxing of bank read data by the bank captured with the request.
  always_comb begin
    sel_a       = cpu_rbank_q ? a_rd1 : a_rd0;
    cpu_rdata_d = cpu_rhalf_q ? sel_a[HW+BUS_W-1:HW] : sel_a[BUS_W-1:0];
    sel_b       = lk_bank2_q ? b_rd1 : b_rd0;
    lk_coeff_d  = {sel_b[HW+BUS_W-1:HW], sel_b[BUS_W-1:0]};
  end

  // CPU read and lookup pipelines; output data holds while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rv_q    <= '0;
      cpu_rbank_q <= 1'b0;
      cpu_rhalf_q <= 1'b0;
      cpu_rdata_q <= '0;
      lk_vld_q    <= '0;
      lk_chan_q   <= '0;
      lk_bank1_q  <= 1'b0;
      lk_bank2_q  <= 1'b0;
      lk_coeff_q  <= '0;
    end else begin
      cpu_rv_q    <= {cpu_rv_q[CPU_RD_LATENCY-2:0], cpu_re & ~cpu_we};
      cpu_rbank_q <= cpu_rd_phys;
      cpu_rhalf_q <= cpu_half;
      if (cpu_rv_q[CPU_RD_LATENCY-2]) cpu_rdata_q <= cpu_rdata_d;
      lk_vld_q    <= {lk_vld_q[LK_LATENCY-2:0], lk_valid};
      if (lk_valid) begin
        lk_chan_q  <= lk_chan;
        lk_bank1_q <= active_bank_q;
      end
      lk_bank2_q  <= lk_bank1_q;
      if (lk_vld_q[LK_LATENCY-2]) lk_coeff_q <= lk_coeff_d;
    end
  end

`ifdef COEFF_PARITY_EN
  logic        lk_perr_d, cpu_perr_d, perr_any;
  logic        parity_err_q;
  logic [15:0] parity_err_cnt_q;

  always_comb begin
    lk_perr_d  = (^sel_b[2*HW-1:HW]) | (^sel_b[HW-1:0]);
    cpu_perr_d = cpu_rhalf_q ? (^sel_a[2*HW-1:HW]) : (^sel_a[HW-1:0]);
    perr_any   = (lk_vld_q[LK_LATENCY-2] & lk_perr_d) |
                 (cpu_rv_q[CPU_RD_LATENCY-2] & cpu_perr_d);
  end

  // Parity error pulse aligned with the output valid, plus saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q     <= 1'b0;
      parity_err_cnt_q <= '0;
    end else begin
      parity_err_q <= perr_any;
      if (perr_any && (parity_err_cnt_q != '1)) parity_err_cnt_q <= parity_err_cnt_q + 16'd1;
    end
  end

  assign parity_err     = parity_err_q;
  assign parity_err_cnt = parity_err_cnt_q;
`endif

  assign cpu_rdata      = cpu_rdata_q;
  assign cpu_rvalid     = cpu_rv_q[CPU_RD_LATENCY-1];
  assign swap_pending   = swap_pending_q;
  assign swap_done      = swap_done_q;
  assign active_bank    = active_bank_q;
  assign lk_coeff       = lk_coeff_q;
  assign lk_coeff_valid = lk_vld_q[LK_LATENCY-1];

endmodule

// File: tb/tb_energy_coeff_lut_dbuf.sv
// Directed bench for energy_coeff_lut_dbuf: vector tables plus hand-written
// swap, collision and reset sequences.
module tb_energy_coeff_lut_dbuf;

  localparam int CHAN_W  = 10;
  localparam int COEFF_W = 64;
  localparam int BUS_W   = 32;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_LK = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cpu_we, cpu_re;
  logic [CHAN_W+1:0]  cpu_addr;
  logic [BUS_W-1:0]   cpu_wdata;
  logic [BUS_W-1:0]   cpu_rdata;
  logic               cpu_rvalid;
  logic               swap_req, frame_sync;
  logic               swap_pending, swap_done, active_bank;
  logic               lk_valid;
  logic [CHAN_W-1:0]  lk_chan;
  logic [COEFF_W-1:0] lk_coeff;
  logic               lk_coeff_valid;
`ifdef COEFF_PARITY_EN
  logic               parity_err;
  logic [15:0]        parity_err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [9:0]  chan;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  always #5 clk = ~clk;

  energy_coeff_lut_dbuf #(.CHAN_W(CHAN_W), .COEFF_W(COEFF_W), .BUS_W(BUS_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_we         (cpu_we),
    .cpu_re         (cpu_re),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_rvalid     (cpu_rvalid),
    .swap_req       (swap_req),
    .frame_sync     (frame_sync),
    .swap_pending   (swap_pending),
    .swap_done      (swap_done),
    .active_bank    (active_bank),
    .lk_valid       (lk_valid),
    .lk_chan        (lk_chan),
    .lk_coeff       (lk_coeff),
    .lk_coeff_valid (lk_coeff_valid)
`ifdef COEFF_PARITY_EN
    ,
    .parity_err     (parity_err),
    .parity_err_cnt (parity_err_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk_addr(input logic sel, input logic [9:0] ch, input logic half);
    return {sel, ch, half};
  endfunction

  function automatic vec_t mk(input int kind, input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [9:0] chan, input logic [63:0] exp);
    vec_t v;
    v.kind = kind; v.addr = addr; v.wdata = wdata; v.chan = chan; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    case (v.kind)
      K_WR: begin
        cpu_we = 1'b1; cpu_addr = v.addr; cpu_wdata = v.wdata;
        tick();
        cpu_we = 1'b0;
      end
      K_RD: begin
        cpu_re = 1'b1; cpu_addr = v.addr;
        tick();
        cpu_re = 1'b0;
        chk({name, "_rv_early"}, {63'd0, cpu_rvalid}, 64'd0);
        tick();
        chk({name, "_rvalid"}, {63'd0, cpu_rvalid}, 64'd1);
        chk({name, "_rdata"}, {32'd0, cpu_rdata}, v.exp);
      end
      default: begin
        lk_valid = 1'b1; lk_chan = v.chan;
        tick();
        lk_valid = 1'b0;
        chk({name, "_lkv1"}, {63'd0, lk_coeff_valid}, 64'd0);
        tick();
        chk({name, "_lkv2"}, {63'd0, lk_coeff_valid}, 64'd0);
        tick();
        chk({name, "_lkv3"}, {63'd0, lk_coeff_valid}, 64'd1);
        chk({name, "_coeff"}, lk_coeff, v.exp);
      end
    endcase
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_seq [4];
    int n;

    rst_n = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    swap_req = 1'b0; frame_sync = 1'b0; lk_valid = 1'b0; lk_chan = '0;

    // Phase A: active = bank 0, shadow = bank 1
    tbl_a.push_back(mk(K_WR, mk_addr(1'b1, 10'd5,    1'b0), 32'h33334444, '0, '0));
    tbl_a.push_back(mk(K_WR, mk_addr(1'b0, 10'd5,    1'b1), 32'h11112222, '0, '0));
    tbl_a.push_back(mk(K_WR, mk_addr(1'b0, 10'd1023, 1'b1), 32'hA5A5A5A5, '0, '0));
    tbl_a.push_back(mk(K_WR, mk_addr(1'b0, 10'd1023, 1'b0), 32'h5A5A5A5A, '0, '0));
    tbl_a.push_back(mk(K_RD, mk_addr(1'b0, 10'd1023, 1'b1), '0, '0, 64'hA5A5A5A5));
    tbl_a.push_back(mk(K_RD, mk_addr(1'b0, 10'd1023, 1'b0), '0, '0, 64'h5A5A5A5A));
    tbl_a.push_back(mk(K_RD, mk_addr(1'b0, 10'd5,    1'b0), '0, '0, 64'h33334444));

    // Phase B: active = bank 1, shadow = bank 0
    tbl_b.push_back(mk(K_WR, mk_addr(1'b0, 10'd5, 1'b0), 32'h01234567, '0, '0));
    tbl_b.push_back(mk(K_WR, mk_addr(1'b1, 10'd5, 1'b1), 32'hDEADBEEF, '0, '0));
    tbl_b.push_back(mk(K_LK, '0, '0, 10'd5, 64'h11112222_33334444));
    tbl_b.push_back(mk(K_LK, '0, '0, 10'd1023, 64'hA5A5A5A5_5A5A5A5A));
    tbl_b.push_back(mk(K_RD, mk_addr(1'b1, 10'd5, 1'b1), '0, '0, 64'h11112222));
    tbl_b.push_back(mk(K_RD, mk_addr(1'b0, 10'd5, 1'b1), '0, '0, 64'hDEADBEEF));
    tbl_b.push_back(mk(K_RD, mk_addr(1'b0, 10'd5, 1'b0), '0, '0, 64'h01234567));

    tick(); tick();
    chk("rst_lk_valid", {63'd0, lk_coeff_valid}, 64'd0);
    chk("rst_lk_coeff", lk_coeff, 64'd0);
    chk("rst_rvalid",   {63'd0, cpu_rvalid}, 64'd0);
    chk("rst_rdata",    {32'd0, cpu_rdata}, 64'd0);
    chk("rst_pending",  {63'd0, swap_pending}, 64'd0);
    chk("rst_done",     {63'd0, swap_done}, 64'd0);
    chk("rst_active",   {63'd0, active_bank}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl_a.size(); i++) run_vec(tbl_a[i], $sformatf("vecA%0d", i));

    // First swap, with state checks at each step
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("arm_pending", {63'd0, swap_pending}, 64'd1);
    chk("arm_active",  {63'd0, active_bank}, 64'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("sw1_active",  {63'd0, active_bank}, 64'd1);
    chk("sw1_done",    {63'd0, swap_done}, 64'd1);
    chk("sw1_pending", {63'd0, swap_pending}, 64'd0);
    tick();
    chk("sw1_done_pulse", {63'd0, swap_done}, 64'd0);

    for (int i = 0; i < tbl_b.size(); i++) run_vec(tbl_b[i], $sformatf("vecB%0d", i));

    do_swap();
    chk("sw2_active", {63'd0, active_bank}, 64'd0);
    run_vec(mk(K_LK, '0, '0, 10'd5, 64'hDEADBEEF_01234567), "lk_new5");

    // Back-to-back lookups across the swap edge (frame_sync with 2nd lookup)
    exp_seq[0] = 64'hDEADBEEF_01234567;
    exp_seq[1] = 64'hDEADBEEF_01234567;
    exp_seq[2] = 64'h11112222_33334444;
    exp_seq[3] = 64'h11112222_33334444;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      lk_valid   = (k < 4);
      lk_chan    = 10'd5;
      frame_sync = (k == 1);
      tick();
      if (lk_coeff_valid) begin
        if (n < 4) chk($sformatf("edge_lk%0d", n), lk_coeff, exp_seq[n]);
        n++;
      end
    end
    lk_valid = 1'b0; frame_sync = 1'b0;
    chk("edge_lk_count", 64'(n), 64'd4);
    chk("edge_active",   {63'd0, active_bank}, 64'd1);

    // Double swap_req -> single toggle
    swap_req = 1'b1; tick();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; frame_sync = 1'b1; tick();
    frame_sync = 1'b0;
    chk("dbl_active", {63'd0, active_bank}, 64'd0);
    chk("dbl_done",   {63'd0, swap_done}, 64'd1);
    frame_sync = 1'b1; tick();
    frame_sync = 1'b0;
    chk("dbl_active2",  {63'd0, active_bank}, 64'd0);
    chk("dbl_pending",  {63'd0, swap_pending}, 64'd0);

    // swap_req with frame_sync while idle: arm only
    swap_req = 1'b1; frame_sync = 1'b1; tick();
    swap_req = 1'b0; frame_sync = 1'b0;
    chk("same_active",  {63'd0, active_bank}, 64'd0);
    chk("same_pending", {63'd0, swap_pending}, 64'd1);
    chk("same_done",    {63'd0, swap_done}, 64'd0);
    tick();
    chk("same_hold",    {63'd0, active_bank}, 64'd0);
    frame_sync = 1'b1; tick();
    frame_sync = 1'b0;
    chk("same_apply",   {63'd0, active_bank}, 64'd1);
    chk("same_done2",   {63'd0, swap_done}, 64'd1);

    // Simultaneous write and read: write wins, no rvalid
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = mk_addr(1'b0, 10'd9, 1'b0); cpu_wdata = 32'hCAFEF00D;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    chk("wr_rd_rv1", {63'd0, cpu_rvalid}, 64'd0);
    tick();
    chk("wr_rd_rv2", {63'd0, cpu_rvalid}, 64'd0);
    tick();
    chk("wr_rd_rv3", {63'd0, cpu_rvalid}, 64'd0);
    run_vec(mk(K_RD, mk_addr(1'b0, 10'd9, 1'b0), '0, '0, 64'hCAFEF00D), "wr_rd_data");

    // Write on the swap edge lands in the bank that becomes active
    run_vec(mk(K_WR, mk_addr(1'b0, 10'd20, 1'b1), 32'h34343434, '0, '0), "pre_wr");
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    frame_sync = 1'b1; cpu_we = 1'b1; cpu_addr = mk_addr(1'b0, 10'd20, 1'b0); cpu_wdata = 32'h12121212;
    tick();
    frame_sync = 1'b0; cpu_we = 1'b0;
    chk("swedge_active", {63'd0, active_bank}, 64'd0);
    run_vec(mk(K_LK, '0, '0, 10'd20, 64'h34343434_12121212), "swedge_lk");

    // Asynchronous reset mid-lookup while armed
    do_swap();
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    lk_valid = 1'b1; lk_chan = 10'd5; cpu_re = 1'b1; cpu_addr = mk_addr(1'b1, 10'd5, 1'b0);
    tick();
    lk_valid = 1'b0; cpu_re = 1'b0;
    chk("prerst_pending", {63'd0, swap_pending}, 64'd1);
    chk("prerst_active",  {63'd0, active_bank}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pending", {63'd0, swap_pending}, 64'd0);
    chk("arst_active",  {63'd0, active_bank}, 64'd0);
    chk("arst_lkv",     {63'd0, lk_coeff_valid}, 64'd0);
    chk("arst_rvalid",  {63'd0, cpu_rvalid}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("flush_lkv%0d", k), {63'd0, lk_coeff_valid}, 64'd0);
    end

`ifdef COEFF_PARITY_EN
    chk("parity_cnt", {48'd0, parity_err_cnt}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/energy_coeff_lut_dbuf.md
Name: energy_coeff_lut_dbuf

Overview:
- Double-buffered per-channel energy-calibration coefficient LUT for the wavelength capture path.
- The CPU writes coefficients into a shadow bank over a 32-bit register-bus port.
- The fabric pixel pipeline reads COEFF_W-bit coefficients from the active bank at a fixed latency.
- Banks swap atomically on a frame boundary, so a lookup never sees a half-updated table.

Parameters:
- CHAN_W, 10, log2 of channel count (depth per bank = 2**CHAN_W).
- COEFF_W, 64, coefficient width; must equal 2*BUS_W.
- BUS_W, 32, CPU data width.

Ports:
- clk  in  1  single clock for CPU and fabric sides.
- rst_n  in  1  asynchronous active-low reset.
- cpu_we  in  1  write strobe, one word per cycle.
- cpu_re  in  1  read strobe.
- cpu_addr  in  CHAN_W+2  bit[CHAN_W+1] = bank select for reads (0 = shadow, 1 = active); bits[CHAN_W:1] = channel; bit[0] = half (0 = low word, 1 = high word).
- cpu_wdata  in  BUS_W  write data.
- cpu_rdata  out  BUS_W  read data.
- cpu_rvalid  out  1  read-data valid.
- swap_req  in  1  pulse; arms a bank swap.
- frame_sync  in  1  pulse; frame boundary.
- swap_pending  out  1  swap armed, not yet applied.
- swap_done  out  1  one-cycle pulse when a swap is applied.
- active_bank  out  1  index of the bank currently serving lookups.
- lk_valid  in  1  lookup request valid.
- lk_chan  in  CHAN_W  lookup channel.
- lk_coeff  out  COEFF_W  coefficient.
- lk_coeff_valid  out  1  coefficient valid.

Behaviour:
- Reset values: all outputs 0; active_bank = 0; swap_pending = 0. RAM contents are not reset.
- Storage: two banks of 2**CHAN_W x COEFF_W, each split into two BUS_W halves with independent write enables.
- CPU write:
  - Always targets the shadow bank (~active_bank); cpu_addr bit[CHAN_W+1] is ignored.
  - Writes half bit[0] of channel bits[CHAN_W:1]. The other half is untouched.
  - cpu_we takes priority over cpu_re in the same cycle; the read is dropped and cpu_rvalid stays 0.
- CPU read:
  - Latency 2: cpu_rvalid and cpu_rdata appear 2 cycles after cpu_re.
  - Bank is chosen by bit[CHAN_W+1] as sampled with cpu_re.
  - Reads are fully pipelined; back-to-back reads are allowed.
- Lookup:
  - Fixed latency 3: input register, RAM read, output register.
  - lk_coeff_valid is lk_valid delayed 3 cycles. lk_coeff holds its last value when valid is low.
  - The bank is sampled with lk_valid at cycle 0. Lookups in flight across a swap complete from the old bank.
- Swap FSM:
  - States IDLE, ARMED.
  - IDLE -> ARMED on swap_req; swap_pending = 1.
  - ARMED -> IDLE on frame_sync: active_bank toggles at the next edge, swap_done pulses once, swap_pending = 0.
  - swap_req while ARMED is ignored; no double toggle.
  - swap_req and frame_sync in the same cycle while IDLE: arm only. The swap applies at the following frame_sync.
  - frame_sync while IDLE: no effect.
- Same-cycle collisions:
  - CPU write and lookup touch different banks by construction, so they never collide.
  - CPU write on the same cycle the swap is applied still lands in the pre-swap shadow bank, which becomes active.
- Reset mid-operation: FSM returns to IDLE, active_bank = 0, pipelines flushed, valids low.

Optional Feature:
- Macro: COEFF_PARITY_EN.
- When defined:
  - Each BUS_W half is stored with an even-parity bit.
  - Parity is checked on lookup and CPU read.
  - Extra outputs: parity_err (1-cycle pulse aligned with the erroneous valid) and parity_err_cnt (16-bit, saturating, cleared by reset).
- When undefined: no parity storage, no extra ports, zero overhead.

Decomposition:
- Shared package energy_cal_pkg holds:
  - LK_LATENCY = 3 and CPU_RD_LATENCY = 2.
  - Swap state enum.
  - Address-field offset constants (half bit, bank-select bit).
- Sub-module energy_coeff_bank: one simple-dual-port bank with per-half write enables and a registered read. It is instantiated twice.

Test Plan:
- Write chan 5 = 0xDEADBEEF_01234567 (two writes: half 0 = 0x01234567, half 1 = 0xDEADBEEF) to shadow, then lookup chan 5 -> old active data. Then swap_req, frame_sync, lookup chan 5 -> 0xDEADBEEF_01234567 exactly 3 cycles later; swap_done pulses once; active_bank = 1.
- Lookups on consecutive cycles across the swap edge -> results before the edge from bank 0, after from bank 1; no dropped or extra valids.
- swap_req twice, then frame_sync -> exactly one toggle. swap_req together with frame_sync while IDLE -> no toggle until the next frame_sync.
- CPU read, shadow bank, chan 1023 half 1 after writing 0xA5A5A5A5 -> cpu_rvalid at +2 with 0xA5A5A5A5. Simultaneous cpu_we and cpu_re -> write occurs, no rvalid.
- rst_n deasserted mid-lookup while ARMED -> all valids 0, swap_pending 0, active_bank 0 immediately (asynchronous).
- COEFF_PARITY_EN: force a bit flip in a stored word, then lookup -> parity_err pulse aligned with lk_coeff_valid, parity_err_cnt = 1.
